// File: rtl/mac_pkg.sv
// mac_pkg: shared widths, shift type and saturation bounds for the MAC
// requantizer and its skid buffer.
package mac_pkg;

    localparam int DEF_IN_W  = 48;
    localparam int DEF_OUT_W = 8;
    localparam int SHIFT_W   = 6;

    typedef logic [SHIFT_W-1:0] shift_t;

    function automatic int sat_max(input int w);
        return (2 ** (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(2 ** (w - 1));
    endfunction

    localparam logic signed [DEF_OUT_W-1:0] SAT_MAX = DEF_OUT_W'(sat_max(DEF_OUT_W));
    localparam logic signed [DEF_OUT_W-1:0] SAT_MIN = DEF_OUT_W'(sat_min(DEF_OUT_W));

    // Shifts past the top data bit would only reproduce the sign, so cap them.
    function automatic shift_t clamp_shift(input shift_t sh, input int lim);
        if (int'(sh) > lim) begin
            return shift_t'(lim);
        end else begin
            return sh;
        end
    endfunction

endpackage

// File: rtl/rq_skid_buf.sv
// rq_skid_buf: 2-entry valid/ready skid buffer (output register + spare).
// s_ready is a flop, so upstream never sees a combinational path from m_ready.
module rq_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         sclr_n,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready
);

    logic [W-1:0] r_out_data;
    logic         r_out_valid;
    logic [W-1:0] r_spare_data;
    logic         r_spare_valid;
    logic         r_s_ready;

    logic         w_push;
    logic         w_out_free;
    logic [W-1:0] w_out_data_nx;
    logic         w_out_valid_nx;
    logic [W-1:0] w_spare_data_nx;
    logic         w_spare_valid_nx;

    assign w_push     = s_valid && r_s_ready;
    assign w_out_free = !r_out_valid || m_ready;

    // Next-state of output register and spare; the spare always drains first to keep order.
    always_comb begin
        w_out_data_nx    = r_out_data;
        w_out_valid_nx   = r_out_valid;
        w_spare_data_nx  = r_spare_data;
        w_spare_valid_nx = r_spare_valid;
        if (r_spare_valid) begin
            if (w_out_free) begin
                w_out_data_nx    = r_spare_data;
                w_out_valid_nx   = 1'b1;
                w_spare_data_nx  = s_data;
                w_spare_valid_nx = w_push;
            end else begin
                w_spare_valid_nx = r_spare_valid;
            end
        end else if (w_out_free) begin
            w_out_valid_nx = w_push;
            if (w_push) begin
                w_out_data_nx = s_data;
            end else begin
                w_out_data_nx = r_out_data;
            end
        end else if (w_push) begin
            w_spare_data_nx  = s_data;
            w_spare_valid_nx = 1'b1;
        end else begin
            w_spare_valid_nx = r_spare_valid;
        end
    end

    // Buffer state and registered ready.
    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_spare_data  <= '0;
            r_spare_valid <= 1'b0;
            r_s_ready     <= 1'b0;
        end else begin
            r_out_data    <= w_out_data_nx;
            r_out_valid   <= w_out_valid_nx;
            r_spare_data  <= w_spare_data_nx;
            r_spare_valid <= w_spare_valid_nx;
            r_s_ready     <= !w_spare_valid_nx;
        end
    end

    assign s_ready = r_s_ready;
    assign m_data  = r_out_data;
    assign m_valid = r_out_valid;

endmodule

// File: rtl/mac_requant.sv
// mac_requant: rounding shift, zero-point add and saturation of the MAC accumulator.
// Optional ReLU before the zero-point add when MAC_REQUANT_RELU_EN is defined.
module mac_requant
    import mac_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             SCLR_N,
    input  logic [IN_W-1:0]  P_IN,
    input  logic             P_VALID,
    output logic             P_READY,
    input  logic [5:0]       SHIFT,
    input  logic [OUT_W-1:0] ZP,
    input  logic             SAT_CLR,
    output logic [OUT_W-1:0] Q_OUT,
    output logic             Q_VALID,
    input  logic             Q_READY,
    output logic [CNT_W-1:0] SAT_CNT
);

    localparam int Y_W = IN_W + 2;
    localparam logic signed [Y_W-1:0] Y_MAX = Y_W'(sat_max(OUT_W));
    localparam logic signed [Y_W-1:0] Y_MIN = Y_W'(sat_min(OUT_W));

    logic                    w_pipe_en;
    shift_t                  w_shift;
    logic signed [IN_W:0]    w_p_ext;
    logic signed [IN_W:0]    w_rnd;
    logic signed [IN_W:0]    w_r;
    logic                    r_s1_valid;
    logic signed [IN_W:0]    r_s1_r;
    logic signed [IN_W:0]    w_r_eff;
    logic signed [Y_W-1:0]   w_y;
    logic [OUT_W-1:0]        w_q;
    logic                    w_sat;
    logic                    r_s2_valid;
    logic [OUT_W-1:0]        r_s2_q;
    logic [CNT_W-1:0]        r_sat_cnt;

    assign w_shift = clamp_shift(SHIFT, IN_W - 1);
    assign w_p_ext = {P_IN[IN_W-1], P_IN};

    // S1 combinational: add half an LSB of the result, then arithmetic shift (round half up).
    always_comb begin
        w_rnd = '0;
        w_r   = w_p_ext;
        if (w_shift == 6'd0) begin
            w_r = w_p_ext;
        end else begin
            w_rnd = {{IN_W{1'b0}}, 1'b1} << (w_shift - 6'd1);
            w_r   = (w_p_ext + w_rnd) >>> w_shift;
        end
    end

    // S1 register, held while the skid buffer cannot take more.
    always_ff @(posedge CLK) begin
        if (!SCLR_N) begin
            r_s1_valid <= 1'b0;
            r_s1_r     <= '0;
        end else if (w_pipe_en) begin
            r_s1_valid <= P_VALID;
            r_s1_r     <= w_r;
        end else begin
            r_s1_valid <= r_s1_valid;
            r_s1_r     <= r_s1_r;
        end
    end

`ifdef MAC_REQUANT_RELU_EN
    assign w_r_eff = r_s1_r[IN_W] ? '0 : r_s1_r;
`else
    assign w_r_eff = r_s1_r;
`endif

    assign w_y = {w_r_eff[IN_W], w_r_eff} + {{(Y_W-OUT_W){ZP[OUT_W-1]}}, ZP};

    // S2 combinational: clamp to the signed output range and flag the clamp.
    always_comb begin
        w_q   = w_y[OUT_W-1:0];
        w_sat = 1'b0;
        if (w_y > Y_MAX) begin
            w_q   = Y_MAX[OUT_W-1:0];
            w_sat = 1'b1;
        end else if (w_y < Y_MIN) begin
            w_q   = Y_MIN[OUT_W-1:0];
            w_sat = 1'b1;
        end else begin
            w_q   = w_y[OUT_W-1:0];
            w_sat = 1'b0;
        end
    end

    // S2 register, advancing together with S1.
    always_ff @(posedge CLK) begin
        if (!SCLR_N) begin
            r_s2_valid <= 1'b0;
            r_s2_q     <= '0;
        end else if (w_pipe_en) begin
            r_s2_valid <= r_s1_valid;
            r_s2_q     <= w_q;
        end else begin
            r_s2_valid <= r_s2_valid;
            r_s2_q     <= r_s2_q;
        end
    end

    // Saturation event counter: clear beats increment, sticks at all-ones.
    always_ff @(posedge CLK) begin
        if (!SCLR_N) begin
            r_sat_cnt <= '0;
        end else if (SAT_CLR) begin
            r_sat_cnt <= '0;
        end else if (w_pipe_en && r_s1_valid && w_sat && (r_sat_cnt != {CNT_W{1'b1}})) begin
            r_sat_cnt <= r_sat_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_sat_cnt <= r_sat_cnt;
        end
    end

    rq_skid_buf #(
        .W (OUT_W)
    ) u_skid (
        .clk     (CLK),
        .sclr_n  (SCLR_N),
        .s_data  (r_s2_q),
        .s_valid (r_s2_valid),
        .s_ready (w_pipe_en),
        .m_data  (Q_OUT),
        .m_valid (Q_VALID),
        .m_ready (Q_READY)
    );

    assign P_READY = w_pipe_en;
    assign SAT_CNT = r_sat_cnt;

endmodule
